// File: rtl/mult_pkg.sv
// Shared definitions for the limb-split pipelined multiplier.
package mult_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LIMB  = 11;

    function automatic int nlimb(input int width, input int limb);
        return (width + limb - 1) / limb;
    endfunction

    // Control that travels alongside the S0/S1 data; the tag width is a
    // top-level parameter, so the optional tag rides in its own registers.
    typedef struct packed {
        logic valid;
        logic neg;
    } stage_ctl_t;

endpackage

// File: rtl/mult_limb_pp.sv
// One registered LIMB x LIMB unsigned partial product, loaded when en is high.
module mult_limb_pp #(
    parameter int LIMB = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [LIMB-1:0]   x,
    input  logic [LIMB-1:0]   y,
    output logic [2*LIMB-1:0] p
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            p <= '0;
        else if (en)
            p <= (2*LIMB)'(x) * (2*LIMB)'(y);
    end

endmodule

// File: rtl/multiplier_pipelined_param.sv
// Three-stage limb-split WIDTH x WIDTH multiplier, signed/unsigned per beat, with
// a single global stall. Define MULT_TAG_EN to carry an in_tag/out_tag sideband.
module multiplier_pipelined_param
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMB  = DEF_LIMB,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULT_TAG_EN
    input  logic [TAG_W-1:0]   in_tag,
    output logic [TAG_W-1:0]   out_tag,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] r
);

    localparam int NL = nlimb(WIDTH, LIMB);
    localparam int PW = NL * LIMB;
    localparam int RW = 2 * WIDTH;

    logic             adv;
    stage_ctl_t       ctl0, ctl1;
    logic             v2;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [PW-1:0]    mag_a, mag_b;
    logic [2*LIMB-1:0] pp [NL*NL];
    logic [RW-1:0]    sum;

    assign adv       = !v2 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v2;

    // -2^(WIDTH-1) negates to itself, which read as unsigned is the right magnitude.
    assign abs_a = (in_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b = (in_signed && b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl0  <= '0;
            mag_a <= '0;
            mag_b <= '0;
        end else if (adv) begin
            ctl0.valid <= in_valid;
            ctl0.neg   <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            mag_a      <= PW'(abs_a);
            mag_b      <= PW'(abs_b);
        end
    end

    for (genvar i = 0; i < NL; i++) begin : g_row
        for (genvar j = 0; j < NL; j++) begin : g_col
            mult_limb_pp #(.LIMB(LIMB)) u_pp (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (adv),
                .x     (mag_a[i*LIMB +: LIMB]),
                .y     (mag_b[j*LIMB +: LIMB]),
                .p     (pp[i*NL+j])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ctl1 <= '0;
        else if (adv)
            ctl1 <= ctl0;
    end

    // Summing at 2*WIDTH bits equals the wide sum truncated, since addition is modular.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NL; i++)
            for (int j = 0; j < NL; j++)
                sum = sum + (RW'(pp[i*NL+j]) << ((i + j) * LIMB));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            r  <= '0;
        end else if (adv) begin
            v2 <= ctl1.valid;
            r  <= ctl1.neg ? -sum : sum;
        end
    end

`ifdef MULT_TAG_EN
    logic [TAG_W-1:0] tag0, tag1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag0    <= '0;
            tag1    <= '0;
            out_tag <= '0;
        end else if (adv) begin
            tag0    <= in_tag;
            tag1    <= tag0;
            out_tag <= tag1;
        end
    end
`endif

endmodule

// File: tb/tb_multiplier_pipelined_param.sv
// Bench for multiplier_pipelined_param: a 32/11 instance for directed cases and a
// 16/5 instance for long random traffic, both against a queue-based arithmetic model.
module tb_multiplier_pipelined_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid32, in_ready32, in_signed32, out_valid32, out_ready32;
    logic [31:0] a32, b32;
    logic [63:0] r32;
    logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [31:0] r16;
`ifdef MULT_TAG_EN
    logic [3:0]  in_tag32, out_tag32, in_tag16, out_tag16;
`endif

    multiplier_pipelined_param #(.WIDTH(32), .LIMB(11), .TAG_W(4)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_signed (in_signed32),
        .a         (a32),
        .b         (b32),
`ifdef MULT_TAG_EN
        .in_tag    (in_tag32),
        .out_tag   (out_tag32),
`endif
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .r         (r32)
    );

    multiplier_pipelined_param #(.WIDTH(16), .LIMB(5), .TAG_W(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_signed (in_signed16),
        .a         (a16),
        .b         (b16),
`ifdef MULT_TAG_EN
        .in_tag    (in_tag16),
        .out_tag   (out_tag16),
`endif
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .r         (r16)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp32[$];
    logic [31:0] exp16[$];
    logic [3:0]  exp_tag16[$];
    bit          stall32 = 1'b0, stall16 = 1'b0;
    logic [63:0] hold_r32;
    logic [31:0] hold_r16;
    logic [3:0]  hold_tag16;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Exact product of w-bit operands, reduced to 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int w, input bit s);
        logic [63:0] ea, eb, p;
        ea = {32'd0, a};
        eb = {32'd0, b};
        if (s && a[w-1]) ea = ea | (~64'd0 << w);
        if (s && b[w-1]) eb = eb | (~64'd0 << w);
        p = ea * eb;
        if (w < 32) p = p & ~(~64'd0 << (2 * w));
        return p;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return (m >> 1) + 32'd1;
            2: return m;
            3: return 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    task automatic cyc32(input bit v, input bit s, input logic [31:0] a, input logic [31:0] b,
                         input bit ordy, output bit acc);
        @(negedge clk);
        in_valid32 = v; in_signed32 = s; a32 = a; b32 = b; out_ready32 = ordy;
        #1;
        if (stall32) begin
            check("hold_v32", 64'(out_valid32), 64'd1);
            check("hold_r32", r32, hold_r32);
        end
        if (out_valid32 && !out_ready32) check("bp_irdy32", 64'(in_ready32), 64'd0);
        if (out_valid32 && out_ready32) begin
            if (exp32.size() == 0) check("extra_out32", 64'(out_valid32), 64'd0);
            else check("r32", r32, exp32.pop_front());
        end
        stall32  = out_valid32 && !out_ready32;
        hold_r32 = r32;
        acc = v && in_ready32;
        if (acc) exp32.push_back(ref_mul(a, b, 32, s));
    endtask

    task automatic cyc16(input bit v, input bit s, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] t, input bit ordy, output bit acc);
        logic [3:0] et;
        @(negedge clk);
        in_valid16 = v; in_signed16 = s; a16 = a; b16 = b; out_ready16 = ordy;
`ifdef MULT_TAG_EN
        in_tag16 = t;
`endif
        #1;
        if (stall16) begin
            check("hold_v16", 64'(out_valid16), 64'd1);
            check("hold_r16", 64'(r16), 64'(hold_r16));
`ifdef MULT_TAG_EN
            check("hold_tag16", 64'(out_tag16), 64'(hold_tag16));
`endif
        end
        if (out_valid16 && out_ready16) begin
            if (exp16.size() == 0) check("extra_out16", 64'(out_valid16), 64'd0);
            else begin
                check("r16", 64'(r16), 64'(exp16.pop_front()));
                et = exp_tag16.pop_front();
`ifdef MULT_TAG_EN
                check("tag16", 64'(out_tag16), 64'(et));
`endif
            end
        end
        stall16  = out_valid16 && !out_ready16;
        hold_r16 = r16;
`ifdef MULT_TAG_EN
        hold_tag16 = out_tag16;
`else
        hold_tag16 = 4'd0;
`endif
        acc = v && in_ready16;
        if (acc) begin
            exp16.push_back(32'(ref_mul({16'd0, a}, {16'd0, b}, 16, s)));
            exp_tag16.push_back(t);
        end
    endtask

    task automatic one32(input string name, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expv);
        bit acc;
        int lat;
        cyc32(1'b1, s, a, b, 1'b1, acc);
        check({name, "_acc"}, 64'(acc), 64'd1);
        lat = 0;
        do begin
            cyc32(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
            lat++;
        end while (!out_valid32 && lat < 8);
        check({name, "_lat"}, 64'(lat), 64'd3);
        check({name, "_r"}, r32, expv);
    endtask

    initial begin
        bit acc;
        int n, first, last, idx, stale, nacc, cycles;
        logic [63:0] got[3];
        logic [31:0] bp_a[4], bp_b[4];

        in_valid32 = 0; in_signed32 = 0; a32 = 0; b32 = 0; out_ready32 = 1;
        in_valid16 = 0; in_signed16 = 0; a16 = 0; b16 = 0; out_ready16 = 1;
`ifdef MULT_TAG_EN
        in_tag32 = 4'd0; in_tag16 = 4'd0;
`endif

        repeat (3) @(negedge clk);
        #1;
        check("rst_ov32", 64'(out_valid32), 64'd0);
        check("rst_r32", r32, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_irdy32", 64'(in_ready32), 64'd1);

        one32("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        one32("smin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        one32("smin_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        one32("zero_neg", 1'b1, 32'd0, 32'hFFFF_FFFF, 64'd0);
        one32("mixed", 1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);

        // Back-to-back beats must emerge on consecutive cycles.
        cyc32(1'b1, 1'b0, 32'd1, 32'd1, 1'b1, acc);
        cyc32(1'b1, 1'b0, 32'd2, 32'd3, 1'b1, acc);
        cyc32(1'b1, 1'b0, 32'd7, 32'd9, 1'b1, acc);
        n = 0; first = -1; last = -1;
        for (int c = 0; c < 8; c++) begin
            cyc32(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
            if (out_valid32) begin
                if (n < 3) got[n] = r32;
                if (first < 0) first = c;
                last = c;
                n++;
            end
        end
        check("b2b_count", 64'(n), 64'd3);
        check("b2b_span", 64'(last - first), 64'd2);
        check("b2b_r0", got[0], 64'd1);
        check("b2b_r1", got[1], 64'd6);
        check("b2b_r2", got[2], 64'd63);

        // Backpressure: five stalled cycles with four beats on offer, then drain.
        for (int k = 0; k < 4; k++) begin
            bp_a[k] = $urandom;
            bp_b[k] = $urandom;
        end
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            cyc32(idx < 4, 1'b1, bp_a[idx % 4], bp_b[idx % 4], 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepted_stalled", 64'(idx), 64'd3);
        for (int c = 0; c < 20; c++) begin
            cyc32(idx < 4, 1'b1, bp_a[idx % 4], bp_b[idx % 4], 1'b1, acc);
            if (acc) idx++;
        end
        check("bp_all_acc", 64'(idx), 64'd4);
        check("bp_drained", 64'(exp32.size()), 64'd0);

        // Reset with beats in flight and one result stalled at the output.
        cyc32(1'b1, 1'b0, 32'd5, 32'd7, 1'b0, acc);
        cyc32(1'b1, 1'b0, 32'd11, 32'd13, 1'b0, acc);
        cyc32(1'b1, 1'b0, 32'd17, 32'd19, 1'b0, acc);
        cyc32(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, acc);
        check("pre_rst_ov", 64'(out_valid32), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ov", 64'(out_valid32), 64'd0);
        check("mid_rst_r", r32, 64'd0);
        check("mid_rst_irdy", 64'(in_ready32), 64'd1);
`ifdef MULT_TAG_EN
        check("mid_rst_tag", 64'(out_tag32), 64'd0);
`endif
        exp32.delete();
        stall32 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            cyc32(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
            if (out_valid32) stale++;
        end
        check("post_rst_stale", 64'(stale), 64'd0);

        for (int c = 0; c < 2000; c++)
            cyc32($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pick(32), pick(32),
                  $urandom_range(0, 2) != 0, acc);
        for (int c = 0; c < 10; c++) cyc32(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
        check("rand32_drained", 64'(exp32.size()), 64'd0);

        nacc = 0; cycles = 0;
        while (nacc < 10000 && cycles < 40000) begin
            cyc16($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, 16'(pick(16)),
                  16'(pick(16)), 4'($urandom), $urandom_range(0, 9) < 7, acc);
            if (acc) nacc++;
            cycles++;
        end
        check("rand16_count", 64'(nacc), 64'd10000);
        for (int c = 0; c < 10; c++) cyc16(1'b0, 1'b0, 16'd0, 16'd0, 4'd0, 1'b1, acc);
        check("rand16_drained", 64'(exp16.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
